// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, register offsets and STATUS bit positions for mmio_uart_tx.
// The PARITY state exists only when UART_PARITY_EN is defined.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } uartStateT;
    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;
    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: power-of-two circular buffer; an occupancy count one bit wider than the
// pointers separates full from empty, and a pop frees room for a same-cycle push.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count;
    logic doPush, doPop;
    assign empty  = count == '0;
    assign full   = count == (AW+1)'(DEPTH);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop) rdPtr <= rdPtr + 1'b1;
            count <= count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
        end
    end
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrData;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TXDATA/STATUS registers and a FIFO.
// Define UART_PARITY_EN to insert an even-parity bit (11-bit frames).
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        irq
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_TOP = TW'(CLKS_PER_BIT - 1);
    uartStateT state;
    logic [TW-1:0] bitTimer;
    logic [2:0] bitIdx;
    logic [7:0] shiftReg, head;
    logic overflow, empty, full, busy, pop, push, txSel, statSel, txBit;
    assign txSel   = DataAdr == BASE_ADDR + TXDATA_OFS;
    assign statSel = DataAdr == BASE_ADDR + STATUS_OFS;
    assign pop     = !empty && (state == IDLE || (state == STOP && bitTimer == '0));
    assign push    = MemWrite && txSel;
    assign busy    = state != IDLE || !empty;
    assign irq     = state == IDLE && empty;
    assign ReadData = statSel ? {29'd0, overflow, full, busy} : 32'd0;
    tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) fifo (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .wrData(WriteData[7:0]), .rdData(head), .empty(empty), .full(full)
    );
    // tx is registered from the current state, so the line lags the FSM by one cycle
    always_comb begin
        txBit = state == START ? 1'b0 : state == DATA ? shiftReg[bitIdx] : 1'b1;
`ifdef UART_PARITY_EN
        if (state == PARITY) txBit = ^shiftReg;
`endif
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            bitTimer <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            tx <= txBit;
            if (push && full && !pop) overflow <= 1'b1;
            else if (MemWrite && statSel && WriteData[STAT_OVF]) overflow <= 1'b0;
            if (state == IDLE) begin
                if (!empty) begin
                    state    <= START;
                    shiftReg <= head;
                    bitTimer <= BIT_TOP;
                end
            end else if (bitTimer != '0) begin
                bitTimer <= bitTimer - 1'b1;
            end else begin
                bitTimer <= BIT_TOP;
                case (state)
                    START: begin
                        state  <= DATA;
                        bitIdx <= '0;
                    end
                    DATA: begin
                        bitIdx <= bitIdx + 1'b1;
`ifdef UART_PARITY_EN
                        if (bitIdx == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        state <= STOP;
`else
                        if (bitIdx == 3'd7) state <= STOP;
`endif
                    end
                    STOP: begin
                        if (!empty) begin
                            state    <= START;
                            shiftReg <= head;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx; frame layout follows UART_PARITY_EN.
module tb_mmio_uart_tx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic tx, irq;
    int testsRun = 0;
    int testsFailed = 0;

    mmio_uart_tx dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drive at a falling edge; returns at the falling edge after the store was sampled
    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        MemWrite = 1'b1;
        DataAdr = adr;
        WriteData = data;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic readStatus(output logic [31:0] v);
        DataAdr = 32'h104;
        #1 v = ReadData;
    endtask

    task automatic checkFrame(input logic [7:0] d, input int skip);
        logic [10:0] bits;
        int nb;
`ifdef UART_PARITY_EN
        bits = {1'b1, ^d, d, 1'b0};
        nb = 11;
`else
        bits = {1'b0, 1'b1, d, 1'b0};
        nb = 10;
`endif
        for (int b = 0; b < nb; b++)
            for (int c = (b == 0 ? skip : 0); c < 16; c++) begin
                check($sformatf("frame%02h_bit%0d_cyc%0d", d, b, c), {31'd0, tx}, {31'd0, bits[b]});
                @(negedge clk);
            end
    endtask

    task automatic watchIdle(input string tag, input int n);
        logic sawLow;
        sawLow = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1) sawLow = 1'b1;
            @(negedge clk);
        end
        check(tag, {31'd0, sawLow}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] st;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd1);
        readStatus(st);
        check("reset_status", st, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single byte, latency and bit timing
        store(32'h100, 32'hFFFF_FF55);
        check("lat_k", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("lat_k1", {31'd0, tx}, 32'd1);
        @(negedge clk);
        checkFrame(8'h55, 0);
        check("single_idle_tx", {31'd0, tx}, 32'd1);
        check("single_irq", {31'd0, irq}, 32'd1);
        readStatus(st);
        check("single_status", st, 32'd0);

        // five back-to-back stores: one popped, four fill the FIFO
        for (int i = 1; i <= 5; i++) store(32'h100, i);
        readStatus(st);
        check("burst_status", st, 32'h3);
        check("burst_irq", {31'd0, irq}, 32'd0);
        for (int i = 1; i <= 5; i++) checkFrame(8'(i), i == 1 ? 2 : 0);
        check("burst_irq_done", {31'd0, irq}, 32'd1);

        // overflow while full, then clear
        for (int i = 0; i < 5; i++) store(32'h100, 32'h11 * (i + 1));
        store(32'h100, 32'hAA);
        readStatus(st);
        check("ovf_status", st, 32'h7);
        store(32'h104, 32'h4);
        readStatus(st);
        check("ovf_cleared", st, 32'h3);
        for (int i = 0; i < 5; i++) checkFrame(8'(32'h11 * (i + 1)), i == 0 ? 4 : 0);
        watchIdle("ovf_aa_dropped", 60);
        readStatus(st);
        check("ovf_final_status", st, 32'd0);

        // push into full FIFO accepted on the cycle the next byte is popped
        for (int i = 1; i <= 5; i++) store(32'h100, 32'h80 + i);
        repeat (156) @(negedge clk);
        store(32'h100, 32'h86);
        readStatus(st);
        check("pushpop_status", st, 32'h3);
        @(negedge clk);
        for (int i = 2; i <= 6; i++) checkFrame(8'(32'h80 + i), 0);
        check("pushpop_irq", {31'd0, irq}, 32'd1);

        // reset during DATA aborts frame and flushes FIFO
        store(32'h100, 32'hC3);
        store(32'h100, 32'h3C);
        repeat (40) @(negedge clk);
        check("abort_pre_busy", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_irq", {31'd0, irq}, 32'd1);
        readStatus(st);
        check("abort_status", st, 32'd0);
        reset = 1'b1;
        watchIdle("abort_lost", 200);

        // store to an unmapped address
        store(32'h60, 32'h19);
        #1 check("unmapped_read", ReadData, 32'd0);
        watchIdle("unmapped_tx", 40);
        readStatus(st);
        check("unmapped_status", st, 32'd0);

        // parity-sensitive frame (odd popcount byte)
        @(negedge clk);
        store(32'h100, 32'h07);
        @(negedge clk);
        @(negedge clk);
        checkFrame(8'h07, 0);
        check("p07_irq", {31'd0, irq}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0100, word-aligned base of the two-register block.
REQ-002 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (minimum 2).
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, minimum 2).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset.
REQ-006 Port MemWrite  input  1  processor store strobe, one cycle per store.
REQ-007 Port DataAdr  input  32  processor data address.
REQ-008 Port WriteData  input  32  processor store data.
REQ-009 Port ReadData  output  32  STATUS register value when DataAdr == BASE_ADDR+4, else 0; combinational.
REQ-010 Port tx  output  1  serial line, idle high.
REQ-011 Port irq  output  1  high while FIFO empty and FSM in IDLE (transmit done).

Function
REQ-012 TXDATA at BASE_ADDR: a store with MemWrite=1 pushes WriteData[7:0]; bits [31:8] are ignored.
REQ-013 STATUS at BASE_ADDR+4: bit0 busy (FSM != IDLE or FIFO non-empty), bit1 fifo_full, bit2 overflow (sticky), bits[31:3] zero.
REQ-014 A store to STATUS with WriteData[2]=1 clears overflow; all other STATUS bits are read-only.
REQ-015 A store to TXDATA while FIFO full is dropped and sets overflow; FIFO contents are unchanged.
REQ-016 Stores to any other address are ignored.
REQ-017 FSM states: IDLE, START, DATA, STOP (plus PARITY under REQ-027).
REQ-018 IDLE: if FIFO non-empty, pop the head into the shift register and go to START; else stay.
REQ-019 START drives tx=0; DATA drives 8 bits LSB first; STOP drives tx=1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-020 STOP -> START directly when FIFO non-empty at the end of STOP (back-to-back frames, no idle gap); otherwise -> IDLE.
REQ-021 Latency: a TXDATA store sampled at edge k with FSM idle and FIFO empty makes tx fall at edge k+2.
REQ-022 Push and pop in the same cycle are both honoured; the occupancy count is unchanged; a push into a full FIFO is accepted when a pop occurs in the same cycle.
REQ-023 FIFO pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by a count of width log2(FIFO_DEPTH)+1.
REQ-024 Bit timer counts down from CLKS_PER_BIT-1 and reloads on every bit boundary.

Reset
REQ-025 When reset=0 at a rising edge: FSM to IDLE, FIFO empty, overflow cleared, bit timer cleared, tx=1, irq=1 from the next cycle on.
REQ-026 Reset asserted mid-frame aborts the frame immediately; tx returns high and the aborted byte is lost.

Configuration
REQ-027 Macro UART_PARITY_EN defined: a PARITY state between DATA and STOP drives even parity of the 8 data bits for CLKS_PER_BIT cycles, giving an 11-bit frame.
REQ-028 Macro UART_PARITY_EN undefined: there is no PARITY state and the frame is 10 bits.

Structure
REQ-029 Package uart_pkg holds the FSM state enum typedef, the register offsets TXDATA_OFS=0 and STATUS_OFS=4, and the STATUS bit index constants.
REQ-030 Sub-module tx_fifo (parameterised by depth and width) holds the storage, pointers and count; the FSM, bit timer, address decode and register logic stay in mmio_uart_tx.

Verification
REQ-031 Store 0x55 to 0x100, default parameters, no parity: tx falls 2 edges later, then bit sequence 0,1,0,1,0,1,0,1,0,1 with 16 cycles per bit; irq=1 after the stop bit.
REQ-032 Five stores back-to-back (0x01..0x05) while idle: the first byte is popped, the other four fill the FIFO, no overflow; the bytes go out as contiguous frames with no idle gap.
REQ-033 Fill the FIFO while it is transmitting, then store 0xAA: STATUS reads 0x7 (busy, full, overflow), 0xAA is never transmitted; storing 0x4 to 0x104 makes STATUS read 0x3.
REQ-034 Drive reset=0 during the DATA state of a frame: tx=1 on the next cycle, STATUS reads 0, irq=1, FIFO empty.
REQ-035 With UART_PARITY_EN defined, store 0x07: the parity bit is 1, the frame lasts 11x16 cycles, and the stop bit is high.
REQ-036 A store to 0x60 with data 0x19 causes no tx activity and no STATUS change.
